// File: rtl/seq_slice_adder.sv
// ============================================================================
// Module   : seq_slice_adder
// Purpose  : Multi-cycle ADD/SUB/CMP/ADDC with a registered SLICE-bit carry
//            chain, valid/ready handshakes and Z/GT-C/N/V flags.
//            Define ADDER_SINGLE_CYCLE_EN to do the full add at acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flag,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NSLICE - 1);

    localparam logic [1:0] c_op_add  = 2'b00;
    localparam logic [1:0] c_op_sub  = 2'b01;
    localparam logic [1:0] c_op_cmp  = 2'b10;
    localparam logic [1:0] c_op_addc = 2'b11;

    generate
        if (WIDTH % SLICE != 0) begin : g_width_check
            $error("seq_slice_adder: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [1:0]       r_ctrl;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
`ifdef ADDER_SINGLE_CYCLE_EN
                    w_state_next = DONE;
`else
                    w_state_next = CALC;
`endif
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == c_last_cnt) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand preparation: SUB/CMP add the one's complement plus carry 1
    // ------------------------------------------------------------------
    logic             w_invert_b;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_invert_b = ctrl[0] ^ ctrl[1];
    assign w_b_eff    = w_invert_b ? ~b : b;
    assign w_c0       = (ctrl == c_op_addc) ? cin : w_invert_b;

    // Operands shift right one slice per cycle; sum bits shift in from the top.
    logic [SLICE:0]   w_slice_sum;
    logic [WIDTH-1:0] w_sum_shift;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;

    assign w_slice_sum = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]}
                       + {{SLICE{1'b0}}, r_carry};

    generate
        if (NSLICE > 1) begin : g_shift_multi
            assign w_sum_shift = {w_slice_sum[SLICE-1:0], r_sum[WIDTH-1:SLICE]};
            assign w_a_shift   = {{SLICE{1'b0}}, r_a[WIDTH-1:SLICE]};
            assign w_b_shift   = {{SLICE{1'b0}}, r_b[WIDTH-1:SLICE]};
        end else begin : g_shift_single
            assign w_sum_shift = w_slice_sum[SLICE-1:0];
            assign w_a_shift   = '0;
            assign w_b_shift   = '0;
        end
    endgenerate

`ifdef ADDER_SINGLE_CYCLE_EN
    logic [WIDTH:0] w_full;
    assign w_full = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_c0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ctrl  <= c_op_add;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_ctrl  <= ctrl;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= w_b_eff;
`ifdef ADDER_SINGLE_CYCLE_EN
            r_sum   <= w_full[WIDTH-1:0];
            r_carry <= w_full[WIDTH];
`else
            r_sum   <= '0;
            r_carry <= w_c0;
`endif
        end else if (r_state == CALC) begin
            r_a     <= w_a_shift;
            r_b     <= w_b_shift;
            r_sum   <= w_sum_shift;
            r_carry <= w_slice_sum[SLICE];
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Flags and result, presented only while a result is offered
    // ------------------------------------------------------------------
    logic w_is_add;
    logic w_z;
    logic w_gt;
    logic w_n;
    logic w_v;

    assign w_is_add = (r_ctrl == c_op_add) || (r_ctrl == c_op_addc);
    assign w_z      = (r_sum == '0);
    assign w_gt     = w_is_add ? r_carry : (r_carry & ~w_z);
    assign w_n      = r_sum[WIDTH-1];
    assign w_v      = w_is_add ? ((r_a_msb == r_b_msb) && (w_n != r_a_msb))
                               : ((r_a_msb != r_b_msb) && (w_n != r_a_msb));

    assign result = (out_valid && (r_ctrl != c_op_cmp)) ? r_sum : '0;
    assign flag   = out_valid ? {w_v, w_n, w_gt, w_z} : 4'b0000;

    logic w_unused;
    assign w_unused = (c_op_sub == 2'b01);

endmodule

`default_nettype wire

// File: tb/tb_seq_slice_adder.sv
// ============================================================================
// Module   : tb_seq_slice_adder
// Purpose  : Directed self-checking bench for seq_slice_adder (32-bit, 8-bit slices).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_slice_adder;

`ifdef ADDER_SINGLE_CYCLE_EN
    localparam int EXP_EDGES = 0;
`else
    localparam int EXP_EDGES = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ctrl;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flag;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_slice_adder #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operation, wait for acceptance, then scramble the inputs.
    task automatic start_op(input string tag, input logic [1:0] op,
                            input logic [31:0] va, input logic [31:0] vb, input logic vc);
        @(negedge clk);
        a        = va;
        b        = vb;
        ctrl     = op;
        cin      = vc;
        in_valid = 1'b1;
        check({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        ctrl     = 2'b01;
        cin      = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(EXP_EDGES));
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic [3:0] flg);
        check({tag, " result"}, result, res);
        check({tag, " flag"}, {28'b0, flag}, {28'b0, flg});
        check({tag, " in_ready_done"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid_after"}, {31'b0, out_valid}, 32'd0);
        check({tag, " in_ready_after"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic full_op(input string tag, input logic [1:0] op, input logic [31:0] va,
                           input logic [31:0] vb, input logic vc,
                           input logic [31:0] res, input logic [3:0] flg);
        start_op(tag, op, va, vb, vc);
        wait_done(tag);
        check_out(tag, res, flg);
        release_out(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ctrl      = 2'b00;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flag", {28'b0, flag}, 32'd0);
        rst = 1'b0;

        full_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0011);
        full_op("sub_neg",  2'b01, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 4'b0100);
        full_op("sub_pos",  2'b01, 32'd7, 32'd5, 1'b0, 32'h0000_0002, 4'b0010);
        full_op("cmp_ovf",  2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0, 4'b1010);
        full_op("cmp_eq",   2'b10, 32'h0000_1234, 32'h0000_1234, 1'b0, 32'h0, 4'b0001);
        full_op("addc_ovf", 2'b11, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 4'b1100);
        full_op("add_nocin", 2'b00, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h7FFF_FFFF, 4'b0000);
        full_op("add_slices", 2'b00, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 4'b0000);

        // Backpressure: result held, new request refused for 10 cycles
        start_op("bp", 2'b01, 32'd7, 32'd5, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            a        = 32'd1;
            b        = 32'd1;
            ctrl     = 2'b00;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp out_valid", {31'b0, out_valid}, 32'd1);
            check("bp result", result, 32'd2);
            check("bp flag", {28'b0, flag}, 32'd2);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_out("bp");

        // Reset mid-operation discards the work
        start_op("rst_mid", 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mid out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid busy", {31'b0, busy}, 32'd0);
        check("rst_mid result", result, 32'd0);
        check("rst_mid flag", {28'b0, flag}, 32'd0);
        begin
            int stale = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) stale++;
            end
            check("rst_mid stale_out", 32'(stale), 32'd0);
        end

        full_op("post_rst", 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
